sprite_layer_compositor: RTL

- Parametrised, pipelined pixel compositor for the 640x480 game display; it replaces the fixed user/bullet/spider/mosquito/fly priority mux.
- Accepts N sprite layers, each with a per-layer enable, and selects the highest-priority valid layer per pixel.
- Expands colour to the VGA DAC width and delays hsync/vsync so they stay aligned with the pixel data.
- Accumulates a per-frame overlap map between layer 0 (player) and every other layer, which the game logic uses for player-damage detection.

---
 rtl/vga_pkg.sv | 16 +
 rtl/color_expand.sv | 19 +
 rtl/sprite_layer_compositor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA display constants and pixel-format helpers for the 640x480 game display.
package vga_pkg;

   localparam int H_ACTIVE   = 640;
   localparam int V_ACTIVE   = 480;
   localparam int MAX_LAYERS = 16;

   // Level of hsync/vsync outside their pulses (active-low syncs).
   localparam logic SYNC_IDLE = 1'b1;

   // Width of one {R,G,B} pixel for a given channel width.
   function automatic int pix_w(input int ch_w);
      return 3 * ch_w;
   endfunction

endpackage : vga_pkg

// File: rtl/color_expand.sv
// Expands one CH_W-bit colour channel to the OUT_W-bit DAC width by
// repeating the input MSB-first and truncating, so full scale maps to full scale.
module color_expand #(
   parameter int CH_W  = 1,
   parameter int OUT_W = 4
) (
   input  logic [CH_W-1:0]  i_ch,
   output logic [OUT_W-1:0] o_ch
);

   // Replicate input bits MSB-first across the output width.
   always_comb begin
      o_ch = {OUT_W{1'b0}};
      for (int i = 0; i < OUT_W; i++) begin
         o_ch[OUT_W-1-i] = i_ch[CH_W-1-(i % CH_W)];
      end
   end

endmodule : color_expand

// File: rtl/sprite_layer_compositor.sv
// Two-stage sprite layer compositor: priority select of N layers over a
// background colour, DAC-width colour expansion, sync delay matching, and a
// per-frame player-overlap collision map published on frame_start.
module sprite_layer_compositor
   import vga_pkg::*;
#(
   parameter int LAYER_COUNT = 6,
   parameter int CH_W        = 1,
   parameter int OUT_W       = 4
) (
   input  logic                            clk25,
   input  logic                            reset_n,
   input  logic                            video_on,
   input  logic                            hsync_in,
   input  logic                            vsync_in,
   input  logic                            frame_start,
   input  logic [LAYER_COUNT-1:0]          layer_valid_flat,
   input  logic [LAYER_COUNT*3*CH_W-1:0]   layer_rgb_flat,
   input  logic [LAYER_COUNT-1:0]          layer_enable,
   input  logic [3*CH_W-1:0]               bg_rgb,
   output logic [OUT_W-1:0]                vga_r,
   output logic [OUT_W-1:0]                vga_g,
   output logic [OUT_W-1:0]                vga_b,
   output logic                            hsync,
   output logic                            vsync,
   output logic [LAYER_COUNT-2:0]          collide_flags,
   output logic                            collide_pulse
);

   localparam int PW = pix_w(CH_W);
   localparam int CW = LAYER_COUNT - 1;

   typedef logic [PW-1:0] pixel_t;

   if (LAYER_COUNT < 2 || LAYER_COUNT > MAX_LAYERS) begin : g_bad_layer_count
      $error("sprite_layer_compositor: LAYER_COUNT out of range");
   end
   if (OUT_W < CH_W) begin : g_bad_out_w
      $error("sprite_layer_compositor: OUT_W must be >= CH_W");
   end

   // Stage-1 registers
   logic [LAYER_COUNT-1:0]    r_vld_en;
   logic [LAYER_COUNT*PW-1:0] r_rgb;
   pixel_t                    r_bg;
   logic                      r_video_on;
   logic                      r_hsync;
   logic                      r_vsync;

   // Collision accumulator
   logic [CW-1:0]             r_acc;

   // Combinational signals
   logic [CW-1:0]             w_hit;
   logic                      w_found;
   pixel_t                    w_sel_pix;
   logic [OUT_W-1:0]          w_exp_r;
   logic [OUT_W-1:0]          w_exp_g;
   logic [OUT_W-1:0]          w_exp_b;

   // Stage 1: capture masked valids, colours, background and raw timing.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         r_vld_en   <= {LAYER_COUNT{1'b0}};
         r_rgb      <= {(LAYER_COUNT*PW){1'b0}};
         r_bg       <= {PW{1'b0}};
         r_video_on <= 1'b0;
         r_hsync    <= SYNC_IDLE;
         r_vsync    <= SYNC_IDLE;
      end else begin
         r_vld_en   <= layer_valid_flat & layer_enable;
         r_rgb      <= layer_rgb_flat;
         r_bg       <= bg_rgb;
         r_video_on <= video_on;
         r_hsync    <= hsync_in;
         r_vsync    <= vsync_in;
      end
   end

   // Per-layer overlap with the player for the pixel being sampled this cycle.
   always_comb begin
      w_hit = {CW{1'b0}};
      for (int k = 1; k < LAYER_COUNT; k++) begin
         w_hit[k-1] = video_on & layer_valid_flat[0] & layer_enable[0] &
                      layer_valid_flat[k] & layer_enable[k];
      end
   end

   // Accumulate overlaps and publish them at frame_start; the frame_start
   // pixel itself seeds the new frame rather than the published one.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         r_acc         <= {CW{1'b0}};
         collide_flags <= {CW{1'b0}};
         collide_pulse <= 1'b0;
      end else if (frame_start) begin
         collide_flags <= r_acc;
         collide_pulse <= |r_acc;
         r_acc         <= w_hit;
      end else begin
         collide_flags <= collide_flags;
         collide_pulse <= 1'b0;
         r_acc         <= r_acc | w_hit;
      end
   end

   // Priority select: lowest-index valid layer wins, background otherwise.
   always_comb begin
      w_found   = 1'b0;
      w_sel_pix = r_bg;
      for (int k = 0; k < LAYER_COUNT; k++) begin
         if (!w_found && r_vld_en[k]) begin
            w_found   = 1'b1;
            w_sel_pix = r_rgb[k*PW +: PW];
         end else begin
            w_found   = w_found;
         end
      end
   end

   color_expand #(.CH_W(CH_W), .OUT_W(OUT_W)) u_exp_r (
      .i_ch (w_sel_pix[2*CH_W +: CH_W]),
      .o_ch (w_exp_r)
   );

   color_expand #(.CH_W(CH_W), .OUT_W(OUT_W)) u_exp_g (
      .i_ch (w_sel_pix[CH_W +: CH_W]),
      .o_ch (w_exp_g)
   );

   color_expand #(.CH_W(CH_W), .OUT_W(OUT_W)) u_exp_b (
      .i_ch (w_sel_pix[0 +: CH_W]),
      .o_ch (w_exp_b)
   );

   // Stage 2: blank outside the active area and register the DAC/sync outputs.
   always_ff @(posedge clk25 or negedge reset_n) begin
      if (!reset_n) begin
         vga_r <= {OUT_W{1'b0}};
         vga_g <= {OUT_W{1'b0}};
         vga_b <= {OUT_W{1'b0}};
         hsync <= SYNC_IDLE;
         vsync <= SYNC_IDLE;
      end else begin
         vga_r <= r_video_on ? w_exp_r : {OUT_W{1'b0}};
         vga_g <= r_video_on ? w_exp_g : {OUT_W{1'b0}};
         vga_b <= r_video_on ? w_exp_b : {OUT_W{1'b0}};
         hsync <= r_hsync;
         vsync <= r_vsync;
      end
   end

endmodule : sprite_layer_compositor
